// File: rtl/classificador_paginas.sv
// Cache-line classifier: two-way hash, a bitmap walk of one cluster per cycle, a per-page suspect table.
// Optional macro CLASSIFICADOR_CONTADORES_EN adds saturating suspect/clean result counters.
module classificador_paginas #(
    parameter int LARGURA_LINHA  = 512,
    parameter int TAM_ENDERECO   = 64,
    parameter int NUM_CLUSTERS   = 8,
    parameter int AMPLITUDE_HASH = 256,
    parameter int TAM_PAGINA     = 4096,
    parameter int NUM_PAGINAS    = 1024,
    localparam int TAM_HASH = $clog2(AMPLITUDE_HASH),
    localparam int CL_W     = $clog2(NUM_CLUSTERS),
    localparam int ADDR_W   = (TAM_HASH > CL_W) ? TAM_HASH : CL_W,
    localparam int DATA_W   = (NUM_CLUSTERS > AMPLITUDE_HASH) ? NUM_CLUSTERS : AMPLITUDE_HASH,
    localparam int IDX_W    = $clog2(NUM_PAGINAS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LARGURA_LINHA-1:0] linha_cache,
    input  logic [TAM_ENDERECO-1:0]  endereco,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_suspeito,
    output logic [TAM_ENDERECO-1:0]  out_endereco,
    input  logic                     prog_we,
    input  logic                     prog_sel,
    input  logic [ADDR_W-1:0]        prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
    input  logic [IDX_W-1:0]         consulta_idx,
    output logic                     consulta_bit,
    output logic [31:0]              cnt_suspeitos,
    output logic [31:0]              cnt_limpos
);

    localparam int NUM_SLICES = LARGURA_LINHA / TAM_HASH;
    localparam int PG_W       = $clog2(TAM_PAGINA);

    typedef enum logic [1:0] {OCIOSO, VARRE, EMITE} estado_t;

    estado_t state_reg, state_next;

    logic [NUM_CLUSTERS-1:0]   primeira_matriz [AMPLITUDE_HASH];
    logic [AMPLITUDE_HASH-1:0] segunda_matriz  [NUM_CLUSTERS];
    logic                      tabela          [NUM_PAGINAS];

    logic [NUM_CLUSTERS-1:0] bitmap_reg;
    logic [TAM_HASH-1:0]     h2_reg;
    logic [TAM_ENDERECO-1:0] endereco_reg;
    logic                    out_suspeito_reg;
    logic [TAM_ENDERECO-1:0] out_endereco_reg;

    logic [TAM_HASH-1:0]     slices [NUM_SLICES];
    logic [TAM_HASH-1:0]     h1, h2;
    logic [CL_W-1:0]         cluster_sel;
    logic [NUM_CLUSTERS-1:0] bitmap_clr;
    logic                    hit, decision, accept;
    logic [IDX_W-1:0]        tabela_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
            assign slices[gi] = linha_cache[gi*TAM_HASH +: TAM_HASH];
        end
    endgenerate

    // Sum wraps naturally at TAM_HASH bits, giving the mod AMPLITUDE_HASH result.
    always_comb begin
        h1 = '0;
        h2 = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            h1 = h1 ^ slices[i];
            h2 = h2 + slices[i];
        end
    end

    always_comb begin
        cluster_sel = '0;
        for (int i = NUM_CLUSTERS - 1; i >= 0; i--) begin
            if (bitmap_reg[i]) cluster_sel = CL_W'(i);
        end
    end

    assign bitmap_clr = bitmap_reg & (bitmap_reg - NUM_CLUSTERS'(1));
    assign hit        = (bitmap_reg != '0) && segunda_matriz[cluster_sel][h2_reg];
    assign decision   = (state_reg == VARRE) &&
                        ((bitmap_reg == '0) || hit || (bitmap_clr == '0));
    assign accept     = (state_reg == OCIOSO) && in_valid;
    assign tabela_idx = endereco_reg[PG_W +: IDX_W];

    always_ff @(posedge clk) begin
        if (!reset) state_reg <= OCIOSO;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            OCIOSO:  if (in_valid) state_next = VARRE;
            VARRE:   if (decision) state_next = EMITE;
            EMITE:   if (out_ready) state_next = OCIOSO;
            default: state_next = OCIOSO;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == OCIOSO);
        out_valid = (state_reg == EMITE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bitmap_reg       <= '0;
            h2_reg           <= '0;
            endereco_reg     <= '0;
            out_suspeito_reg <= 1'b0;
            out_endereco_reg <= '0;
        end else begin
            if (accept) begin
                bitmap_reg   <= primeira_matriz[h1];
                h2_reg       <= h2;
                endereco_reg <= endereco;
            end else if (state_reg == VARRE) begin
                bitmap_reg <= bitmap_clr;
            end
            if (decision) begin
                out_suspeito_reg <= hit;
                out_endereco_reg <= endereco_reg;
            end
        end
    end

    // Matrices and table are reset-cleared, so they are held in registers rather than block RAM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < AMPLITUDE_HASH; i++) primeira_matriz[i] <= '0;
            for (int i = 0; i < NUM_CLUSTERS; i++)   segunda_matriz[i]  <= '0;
            for (int i = 0; i < NUM_PAGINAS; i++)    tabela[i]          <= 1'b0;
        end else begin
            if (prog_we) begin
                if (!prog_sel) begin
                    if ({{(32-ADDR_W){1'b0}}, prog_addr} < 32'(AMPLITUDE_HASH))
                        primeira_matriz[prog_addr[TAM_HASH-1:0]] <= prog_data[NUM_CLUSTERS-1:0];
                end else begin
                    if ({{(32-ADDR_W){1'b0}}, prog_addr} < 32'(NUM_CLUSTERS))
                        segunda_matriz[prog_addr[CL_W-1:0]] <= prog_data[AMPLITUDE_HASH-1:0];
                end
            end
            if (decision) tabela[tabela_idx] <= hit;
        end
    end

    assign out_suspeito = out_suspeito_reg;
    assign out_endereco = out_endereco_reg;
    assign consulta_bit = tabela[consulta_idx];

`ifdef CLASSIFICADOR_CONTADORES_EN
    logic [31:0] cnt_suspeitos_reg, cnt_limpos_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_suspeitos_reg <= '0;
            cnt_limpos_reg    <= '0;
        end else if (decision) begin
            if (hit) begin
                if (cnt_suspeitos_reg != '1) cnt_suspeitos_reg <= cnt_suspeitos_reg + 32'd1;
            end else begin
                if (cnt_limpos_reg != '1) cnt_limpos_reg <= cnt_limpos_reg + 32'd1;
            end
        end
    end

    assign cnt_suspeitos = cnt_suspeitos_reg;
    assign cnt_limpos    = cnt_limpos_reg;
`else
    assign cnt_suspeitos = '0;
    assign cnt_limpos    = '0;
`endif

endmodule

// File: tb/tb_classificador_paginas.sv
// Scoreboard bench for classificador_paginas: driver pushes expected results, monitor pops on out_valid.
module tb_classificador_paginas;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] linha_cache;
    logic [63:0]  endereco;
    logic         out_valid;
    logic         out_ready;
    logic         out_suspeito;
    logic [63:0]  out_endereco;
    logic         prog_we;
    logic         prog_sel;
    logic [7:0]   prog_addr;
    logic [255:0] prog_data;
    logic [9:0]   consulta_idx;
    logic         consulta_bit;
    logic [31:0]  cnt_suspeitos;
    logic [31:0]  cnt_limpos;

    classificador_paginas dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .linha_cache(linha_cache), .endereco(endereco),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_suspeito(out_suspeito), .out_endereco(out_endereco),
        .prog_we(prog_we), .prog_sel(prog_sel), .prog_addr(prog_addr), .prog_data(prog_data),
        .consulta_idx(consulta_idx), .consulta_bit(consulta_bit),
        .cnt_suspeitos(cnt_suspeitos), .cnt_limpos(cnt_limpos)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        sus;
        bit [63:0] addr;
        int        lat;
        int        stall;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    time  acc_time = 0;
    time  rdy_time = 0;

    logic [511:0] line_zero, line_a, line_b;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic prog(input logic sel, input logic [7:0] addr, input logic [255:0] data);
        @(negedge clk);
        prog_we = 1'b1; prog_sel = sel; prog_addr = addr; prog_data = data;
        @(posedge clk);
        #1 prog_we = 1'b0;
    endtask

    // Offer a line; expected latency counts edges from the accept edge to the first edge out_valid is seen.
    task automatic send(input logic [511:0] l, input logic [63:0] a, input bit push,
                        input bit sus, input int lat, input int stall, input bit b2b);
        exp_t e;
        int k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        linha_cache = l; endereco = a; in_valid = 1'b1;
        e.sus = sus; e.addr = a; e.lat = lat; e.stall = stall;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        acc_time = $time;
        if (b2b) chk("b2b_accept_gap", 64'(acc_time - rdy_time), 64'd10);
        #1 in_valid = 1'b0;
        $display("line addr=%0h pushed=%0d exp_sus=%0d exp_lat=%0d", a, push, sus, lat);
    endtask

    task automatic drain;
        int k = 0;
        while ((exp_q.size() != 0 || !in_ready) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic chk_tab(input logic [9:0] idx, input logic expv);
        @(negedge clk);
        consulta_idx = idx;
        #1 chk($sformatf("table[%0h]", idx), 64'(consulta_bit), 64'(expv));
    endtask

    // Monitor: on each new out_valid pop and compare, optionally stall, then handshake.
    initial begin
        exp_t e;
        int   lat;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_out: got out_valid=1 expected 0 addr=%0h", out_endereco);
                    e.stall = 0; e.sus = out_suspeito; e.addr = out_endereco;
                end else begin
                    e = exp_q.pop_front();
                    lat = int'(($time - acc_time + 5) / 10);
                    chk("latency", 64'(lat), 64'(e.lat));
                    chk("out_suspeito", 64'(out_suspeito), 64'(e.sus));
                    chk("out_endereco", out_endereco, e.addr);
                    $display("result addr=%0h sus=%0d lat=%0d", out_endereco, out_suspeito, lat);
                end
                for (int i = 0; i < e.stall; i++) begin
                    @(negedge clk);
                    chk("stall_out_valid", 64'(out_valid), 64'd1);
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                    chk("stall_suspeito", 64'(out_suspeito), 64'(e.sus));
                    chk("stall_endereco", out_endereco, e.addr);
                end
                out_ready = 1'b1;
                @(posedge clk);
                rdy_time = $time;
                @(negedge clk);
                out_ready = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; linha_cache = '0; endereco = '0;
        prog_we = 1'b0; prog_sel = 1'b0; prog_addr = '0; prog_data = '0; consulta_idx = '0;
        // line_a: slices 0F,F0,01 -> h1=FE, h2=00.  line_b: slice 40 -> h1=40, h2=40.
        line_zero = '0;
        line_a = '0; line_a[7:0] = 8'h0F; line_a[15:8] = 8'hF0; line_a[23:16] = 8'h01;
        line_b = '0; line_b[7:0] = 8'h40;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_suspeito", 64'(out_suspeito), 64'd0);
        chk("rst_out_endereco", out_endereco, 64'd0);
        chk("rst_cnt_sus", 64'(cnt_suspeitos), 64'd0);
        chk("rst_cnt_clean", 64'(cnt_limpos), 64'd0);

        // Empty bitmap: clean after one VARRE cycle.
        send(line_zero, 64'h5000, 1'b1, 1'b0, 2, 0, 1'b0);
        drain();
        chk_tab(10'h005, 1'b0);

        // Bitmap {3,5}, hit on cluster 5 (second set bit).
        prog(1'b0, 8'hFE, 256'h28);
        prog(1'b1, 8'd5, 256'h1);
        send(line_a, 64'h123000, 1'b1, 1'b1, 3, 0, 1'b0);
        drain();
        chk_tab(10'h123, 1'b1);

        // Clear cluster 5; an out-of-range row write must not alias onto it.
        prog(1'b1, 8'd5, 256'h0);
        prog(1'b1, 8'd13, {256{1'b1}});
        prog(1'b0, 8'h40, 256'hFF);
        prog(1'b1, 8'd7, 256'h1 << 64);
        send(line_a, 64'h7000, 1'b1, 1'b0, 3, 10, 1'b0);
        // Full bitmap, hit only on cluster 7; accepted one edge after the stalled handshake.
        send(line_b, 64'h9000, 1'b1, 1'b1, 9, 0, 1'b1);
        drain();
        chk_tab(10'h007, 1'b0);
        chk_tab(10'h009, 1'b1);

        prog(1'b1, 8'd7, 256'h0);
        send(line_b, 64'hA000, 1'b1, 1'b0, 9, 0, 1'b0);
        drain();
        chk_tab(10'h00A, 1'b0);

        // Early exit on first set bit; page index aliases with 0x5000 and overwrites it.
        prog(1'b1, 8'd3, 256'h1);
        send(line_a, 64'h405000, 1'b1, 1'b1, 2, 0, 1'b0);
        drain();
        chk_tab(10'h005, 1'b1);
`ifdef CLASSIFICADOR_CONTADORES_EN
        chk("cnt_suspeitos", 64'(cnt_suspeitos), 64'd3);
        chk("cnt_limpos", 64'(cnt_limpos), 64'd3);
`else
        chk("cnt_suspeitos", 64'(cnt_suspeitos), 64'd0);
        chk("cnt_limpos", 64'(cnt_limpos), 64'd0);
`endif

        // Reset in the middle of an 8-cycle walk: line is discarded.
        send(line_b, 64'hB000, 1'b0, 1'b0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_endereco", out_endereco, 64'd0);
        chk("midrst_cnt_sus", 64'(cnt_suspeitos), 64'd0);
        chk("midrst_cnt_clean", 64'(cnt_limpos), 64'd0);
        chk_tab(10'h005, 1'b0);
        chk_tab(10'h00B, 1'b0);

        // Matrices cleared: both lines now see an empty bitmap.
        send(line_a, 64'h405000, 1'b1, 1'b0, 2, 0, 1'b0);
        drain();
        send(line_b, 64'h9000, 1'b1, 1'b0, 2, 0, 1'b0);
        drain();
        chk_tab(10'h009, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
